// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing the uart_control TX write port
// Optional post-write idle gap is enabled by defining UART_GAP_EN.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic                          clk_auto,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          uart_wrfull,
   output logic                          uart_write,
   output logic [DATA_WIDTH-1:0]         uart_writedata,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);
   localparam int GW = $clog2(NUM_REQ);

`ifdef UART_GAP_EN
   localparam int CW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
   logic [CW-1:0] gap_cnt;
   logic          gap_done;
`else
   typedef enum logic {IDLE, WRITE} state_t;
`endif

   state_t                state, state_nxt;
   logic [GW-1:0]         last;
   logic [GW-1:0]         sel;
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  grant;

   // Scan farthest-to-nearest from last so the nearest asserted requester wins.
   always_comb begin
      int            idx;
      logic [GW-1:0] idx_b;
      sel       = last;
      sel_valid = 1'b0;
      idx       = 0;
      idx_b     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx   = (int'(last) + k) % NUM_REQ;
         idx_b = GW'(idx);
         if (req[idx_b]) begin
            sel       = idx_b;
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == GW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign grant = (state == IDLE) && sel_valid && !uart_wrfull;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk_auto or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      uart_write = 1'b0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = WRITE;
         end
         WRITE: begin
            if (!uart_wrfull) begin
               uart_write = 1'b1;
`ifdef UART_GAP_EN
               state_nxt  = GAP;
`else
               state_nxt  = IDLE;
`endif
            end
         end
`ifdef UART_GAP_EN
         GAP: begin
            if (gap_done) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = uart_write && (grant_id == GW'(i));
      end
   end

   // Byte is latched at grant so a requester may drop req before the write.
   always_ff @(posedge clk_auto or negedge reset_n) begin
      if (!reset_n) begin
         last           <= GW'(NUM_REQ - 1);
         grant_id       <= '0;
         uart_writedata <= '0;
      end else begin
         if (grant) begin
            grant_id       <= sel;
            uart_writedata <= sel_data;
         end
         if (uart_write) last <= grant_id;
      end
   end

`ifdef UART_GAP_EN
   assign gap_done = (gap_cnt == CW'(GAP_CYCLES - 1));

   always_ff @(posedge clk_auto or negedge reset_n) begin
      if (!reset_n)           gap_cnt <= '0;
      else if (state == GAP)  gap_cnt <= gap_done ? '0 : gap_cnt + CW'(1);
   end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
// Transaction-level model tracks pending byte, gap countdown and round-robin pointer.
module tb_uart_tx_scheduler;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int GAPC = 4;
`ifdef UART_GAP_EN
   localparam int MGAP = GAPC;
`else
   localparam int MGAP = 0;
`endif

   logic          clk_auto = 1'b0;
   logic          reset_n  = 1'b1;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  ack;
   logic          uart_wrfull;
   logic          uart_write;
   logic [DW-1:0] uart_writedata;
   logic [1:0]    grant_id;
   logic          busy;

   uart_tx_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAPC)) dut (
      .clk_auto(clk_auto), .reset_n(reset_n), .req(req), .req_data(req_data),
      .ack(ack), .uart_wrfull(uart_wrfull), .uart_write(uart_write),
      .uart_writedata(uart_writedata), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk_auto = ~clk_auto;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int m_pending, m_gap, m_last, m_gid;
   logic [DW-1:0] m_data;
   bit rec = 0;
   logic [DW-1:0] wr_bytes[$];
   int wr_cycs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_pending = 0; m_gap = 0; m_last = N - 1; m_gid = 0; m_data = '0;
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_write", 32'(uart_write), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_writedata", 32'(uart_writedata), 32'd0);
      @(posedge clk_auto);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic f);
      bit exp_w;
      req = r; req_data = d; uart_wrfull = f;
      #3;
      exp_w = (m_pending != 0) && !f;
      chk("uart_write", 32'(uart_write), 32'(exp_w));
      chk("ack", 32'(ack), exp_w ? (32'd1 << m_gid) : 32'd0);
      chk("writedata", 32'(uart_writedata), 32'(m_data));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("busy", 32'(busy), 32'((m_pending != 0) || (m_gap > 0)));
      if (rec && uart_write) begin
         wr_bytes.push_back(uart_writedata);
         wr_cycs.push_back(cyc);
      end
      @(posedge clk_auto);
      #1;
      cyc++;
      if (m_pending != 0) begin
         if (!f) begin
            m_pending = 0; m_last = m_gid; m_gap = MGAP;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (r != 0 && !f) begin
         m_gid = pick(r, m_last);
         m_data = d[m_gid*DW +: DW];
         m_pending = 1;
      end
   endtask

   task automatic start_rec();
      wr_bytes.delete(); wr_cycs.delete(); rec = 1;
   endtask

   initial begin
      logic [7:0] exp3 [5];
      exp3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      req = '0; req_data = '0; uart_wrfull = 1'b0;
      #1;
      do_reset();

      // reset during WRITE with every requester active
      step(4'b1111, 32'h13121110, 1'b0);
      do_reset();
      start_rec();
      step(4'b1111, 32'h13121110, 1'b0);
      step(4'b1111, 32'h13121110, 1'b0);
      rec = 0;
      chk("t1_count", 32'(wr_bytes.size()), 32'd1);
      if (wr_bytes.size() > 0) chk("t1_byte", 32'(wr_bytes[0]), 32'h10);

      // single requester 1
      do_reset();
      step(4'b0000, 32'h0, 1'b0);
      start_rec();
      step(4'b0010, 32'h00004100, 1'b0);
      step(4'b0010, 32'h00004100, 1'b0);
      step(4'b0000, 32'h0, 1'b0);
      rec = 0;
      chk("t2_count", 32'(wr_bytes.size()), 32'd1);
      if (wr_bytes.size() > 0) chk("t2_byte", 32'(wr_bytes[0]), 32'h41);
      chk("t2_grant_id", 32'(grant_id), 32'd1);

`ifndef UART_GAP_EN
      // four persistent requesters rotate
      do_reset();
      start_rec();
      for (int i = 0; i < 10; i++) step(4'b1111, 32'h13121110, 1'b0);
      rec = 0;
      chk("t3_count", 32'(wr_bytes.size()), 32'd5);
      for (int i = 0; i < 5 && i < wr_bytes.size(); i++) chk("t3_byte", 32'(wr_bytes[i]), 32'(exp3[i]));
      for (int i = 1; i < wr_cycs.size(); i++) chk("t3_spacing", 32'(wr_cycs[i] - wr_cycs[i-1]), 32'd2);
`else
      // gap spacing with one persistent requester
      do_reset();
      start_rec();
      for (int i = 0; i < 15; i++) step(4'b0001, 32'h000000A5, 1'b0);
      rec = 0;
      chk("t6_count", 32'(wr_bytes.size()), 32'd3);
      for (int i = 1; i < wr_cycs.size(); i++) chk("t6_spacing", 32'(wr_cycs[i] - wr_cycs[i-1]), 32'(GAPC + 2));
`endif

      // full FIFO blocks grant
      step(4'b0000, 32'h0, 1'b0);
      for (int i = 0; i < 3 * MGAP; i++) step(4'b0000, 32'h0, 1'b0);
      start_rec();
      for (int i = 0; i < 10; i++) step(4'b0100, 32'h00550000, 1'b1);
      chk("t4_blocked", 32'(wr_bytes.size()), 32'd0);
      step(4'b0100, 32'h00550000, 1'b0);
      step(4'b0100, 32'h00550000, 1'b0);
      rec = 0;
      chk("t4_count", 32'(wr_bytes.size()), 32'd1);
      if (wr_bytes.size() > 0) chk("t4_byte", 32'(wr_bytes[0]), 32'h55);
      for (int i = 0; i < MGAP + 1; i++) step(4'b0000, 32'h0, 1'b0);

      // full FIFO stalls WRITE for 3 cycles
      start_rec();
      step(4'b1000, 32'h77000000, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1000, 32'h77000000, 1'b1);
      step(4'b1000, 32'h77000000, 1'b0);
      step(4'b0000, 32'h0, 1'b0);
      rec = 0;
      chk("t5_count", 32'(wr_bytes.size()), 32'd1);
      if (wr_bytes.size() > 0) chk("t5_byte", 32'(wr_bytes[0]), 32'h77);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step(N'($urandom_range(0, 15)), 32'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single byte-wide transmit write port of the uart_control core between NUM_REQ requesters (core send path, debug/monitor, boot loader, etc.). It grants one requester at a time, latches that requester's byte, and issues exactly one write pulse into the UART TX FIFO. It respects the core's FIFO-full backpressure and acknowledges the winning requester. It sits between the requesters and the uart_control writedata/write inputs.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
DATA_WIDTH, 8, byte width of each request and of uart_writedata.
GAP_CYCLES, 16, idle cycles inserted after each write; used only with UART_GAP_EN; must be >= 1.

Ports:
clk_auto  input  1  system clock, 50 MHz; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  per-requester send request; level, held until ack.
req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
ack  output  NUM_REQ  one-hot, one-cycle pulse: byte from requester i written to UART.
uart_wrfull  input  1  TX FIFO full from uart_control; no write while high.
uart_write  output  1  write strobe to uart_control.
uart_writedata  output  DATA_WIDTH  byte to uart_control.
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock (clk_auto). reset_n is asynchronous, active-low.
- Reset values: state=IDLE, uart_write=0, ack=0, uart_writedata=0, grant_id=0, busy=0, last-grant pointer=NUM_REQ-1, so requester 0 has first priority after reset. Gap counter=0.
- States:
  - IDLE: at an edge where |req=1 and uart_wrfull=0, select the first asserted req scanning from (last+1) mod NUM_REQ upward with wrap. Register grant_id and latch the selected req_data into uart_writedata. Go to WRITE.
  - If uart_wrfull=1 or no req is asserted, stay in IDLE.
- WRITE:
  - uart_write = (state==WRITE) & ~uart_wrfull, combinational.
  - ack[grant_id] is asserted under the same condition, same cycle.
  - On the edge where that condition is true: last <= grant_id, then go to GAP (UART_GAP_EN) or IDLE.
  - While uart_wrfull=1, hold WRITE with uart_write=0 and ack=0. uart_writedata stays stable.
- Requester rules:
  - Data is latched at grant. A requester that drops req after grant is still written and acked.
  - A requester that holds req after ack requests another byte and competes again normally.
- Throughput: back-to-back grants produce one write every 2 cycles (IDLE, WRITE). Round-robin guarantees each of NUM_REQ persistent requesters one write per NUM_REQ grants.
- Simultaneous events: several req rising together resolve by round-robin order only. A req arriving during WRITE or GAP waits for IDLE.
- Exactly one ack per uart_write pulse. Never more than one ack bit set.
- grant_id holds its value outside WRITE. busy = (state != IDLE).
- Reset mid-operation: everything returns to reset values asynchronously. A pending byte is dropped with no ack.

Optional Feature:
Macro UART_GAP_EN.
- Defined: WRITE goes to GAP. GAP counts GAP_CYCLES cycles (counter 0..GAP_CYCLES-1) and then returns to IDLE. Requests are ignored during GAP. Back-to-back writes are spaced GAP_CYCLES+2 cycles.
- Undefined: no GAP state and no counter. WRITE returns directly to IDLE, and GAP_CYCLES is unused.

Test Plan:
1. Assert reset_n=0 during WRITE with req=4'b1111 -> uart_write=0, ack=0, busy=0 immediately. After release, the first write comes from requester 0.
2. Only req[1]=1 with data 0x41 and wrfull=0 -> the cycle after req is sampled, uart_write=1 for exactly one cycle with writedata=0x41 and ack=4'b0010 in the same cycle. grant_id=1.
3. req=4'b1111 held with data 0x10,0x11,0x12,0x13 (no gap) -> writes 0x10,0x11,0x12,0x13,0x10, spaced exactly 2 cycles apart, each with the matching one-hot ack.
4. uart_wrfull=1 while req[2]=1 (data 0x55) for 10 cycles -> no uart_write, state IDLE. Drop wrfull -> write of 0x55 two cycles later, ack=4'b0100.
5. uart_wrfull rises during WRITE for 3 cycles -> uart_write and ack stay low for 3 cycles, then a single pulse with the unchanged byte. There is exactly one ack.
6. With UART_GAP_EN and GAP_CYCLES=4, req[0]=1 held -> write pulses spaced 6 cycles apart. busy stays high through GAP.
